mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-ported synchronous RAM among three CPU memory requesters:
//   instruction fetch (read), data read, and data write.
// - Sits between the 7-stage pipeline's memory interface and the RAM macro.
// - Issues at most one RAM command per cycle and returns read data to its owner
//   after a fixed RAM latency.
// - Produces per-requester grants that the pipeline uses to stall fetch or memory stages.
// PARAMETERS
// - RD_LATENCY  1   cycles from RAM command to valid ram_rdata (legal 1..4)
// - STARVE_MAX  3   consecutive denied fetch cycles before fetch is forced to win
// - AW          32  address width
// PORTS
// - clk        in   1   rising-edge clock
// - rst_n      in   1   asynchronous active-low reset
// - flush      in   1   pipeline flush; squashes in-flight fetch responses
// - if_req     in   1   fetch read request; held with if_addr until if_gnt
// - if_addr    in   AW  fetch byte address
// - if_gnt     out  1   fetch request accepted this cycle
// - if_rvalid  out  1   fetch read data valid (1-cycle pulse)
// - if_rdata   out  32  fetch read data
// - d_req      in   1   data request; held with d_we/d_addr/d_wdata until d_gnt
// - d_we       in   4   byte write enables; 0 = read, nonzero = write
// - d_addr     in   AW  data byte address
// - d_wdata    in   32  store data
// - d_gnt      out  1   data request accepted this cycle
// - d_rvalid   out  1   data read data valid (1-cycle pulse; never for writes)
// - d_rdata    out  32  data read data
// - ram_en     out  1   RAM command valid
// - ram_we     out  4   RAM byte write enables
// - ram_addr   out  AW  RAM byte address
// - ram_wdata  out  32  RAM write data
// - ram_rdata  in   32  RAM read data, valid RD_LATENCY cycles after the command
// BEHAVIOUR
// - Reset: all outputs 0; starvation counter 0; tag pipeline cleared to TAG_NONE.
//   Asserting rst_n low mid-operation drops all in-flight responses; no rvalid
//   may follow a reset.
// - Grants are combinational from the current requests and registered state.
//   At most one of if_gnt/d_gnt is high per cycle.
//   ram_en = if_gnt | d_gnt; the RAM command fields come from the granted requester.
// - Priority: data (read or write) over fetch, unless starve_cnt == STARVE_MAX;
//   then fetch wins that cycle.
// - starve_cnt:
//   - +1 on (if_req & ~if_gnt), saturating at STARVE_MAX.
//   - Reset to 0 on if_gnt or ~if_req.
// - Tag pipe: RD_LATENCY-deep shift register. Stage 0 loads the tag of the
//   granted request:
//   - TAG_IF for a fetch grant.
//   - TAG_D for a data grant with d_we == 0.
//   - TAG_NONE for a write or an idle cycle.
// - At the tail of the tag pipe:
//   - TAG_IF: if_rvalid = 1 and if_rdata = ram_rdata.
//   - TAG_D: d_rvalid = 1 and d_rdata = ram_rdata.
//   - A non-owner rdata output is driven to 0 (no stale data).
// - flush: every TAG_IF entry in the pipe becomes TAG_NONE, including the tail
//   in the same cycle, so if_rvalid = 0 while flush = 1.
//   - A fetch grant issued in a flush cycle is tagged TAG_NONE.
//   - TAG_D entries are never squashed.
// - Simultaneous fetch + data request in the same cycle: exactly one grant.
//   The loser keeps its request asserted; the arbiter holds no request storage.
// - Throughput: one command per cycle. Back-to-back grants to the same requester
//   are allowed.
// - Requester protocol violations (changing address while req=1 and gnt=0) are
//   unsupported; the bench asserts on them.
// STRUCTURE
// - Shared package cpu_mem_pkg:
//   - 2-bit tag typedef with constants TAG_NONE=0, TAG_IF=1, TAG_D=2.
//   - Constant WE_NONE = 4'b0000.
// - Sub-module resp_tag_pipe:
//   - Parameterised RD_LATENCY shift register of tags with async active-low reset.
//   - Input: flush-squash.
//   - Output: tail tag.
// - Top level: priority/starvation logic, command mux, response demux.
// TESTING
// - Reset: hold rst_n=0 with if_req=1 -> all outputs 0.
//   Release rst_n -> if_gnt=1 in the first cycle; if_rvalid RD_LATENCY cycles later.
// - Fetch only: if_req=1 with if_addr 0x0,0x4,0x8 on consecutive cycles ->
//   3 back-to-back if_gnt; if_rvalid pulses in cycles 1,2,3 with matching RAM words.
// - Collision: if_req=1 and d_req=1 (read 0x100) in the same cycle ->
//   d_gnt=1, if_gnt=0; the next cycle (d_req=0) gives if_gnt=1.
//   d_rvalid precedes if_rvalid by exactly 1 cycle.
// - Starvation: d_req held high for 10 cycles alongside if_req ->
//   if_gnt in cycle 4 (STARVE_MAX=3); d_gnt in all other cycles.
// - Write: d_we=4'b0011, d_addr=0x40, d_wdata=0xDEADBEEF ->
//   ram_we=4'b0011 for one cycle; no d_rvalid.
//   A later read of 0x40 returns low half 0xBEEF.
// - Flush: a fetch is granted, then flush=1 in the cycle before its response ->
//   if_rvalid stays 0.
//   A data read granted in the same window still gets d_rvalid.
//   Assert rst_n low mid-flight -> no rvalid afterwards.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory port arbiter.
// Holds the response tag type that marks which requester owns each RAM read
// in flight. It also holds the "no write" byte-enable constant and a small
// helper that removes fetch ownership when the pipeline flushes.
package cpu_mem_pkg;

   // Owner of a RAM command as it travels through the read-latency pipe
   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_IF   = 2'd1,
      TAG_D    = 2'd2
   } tag_e;

   localparam logic [3:0] WE_NONE = 4'b0000;

   // A flush cancels fetch responses only; data responses always complete
   function automatic tag_e squashTag(input tag_e tag, input logic flush);
      return (flush && (tag == TAG_IF)) ? TAG_NONE : tag;
   endfunction

endpackage

// File: rtl/resp_tag_pipe.sv
// Response tag delay line for the memory port arbiter.
// It tracks the owner of every RAM command until its read data comes back.
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset; clears every stage to TAG_NONE
//   flush_i    squashes every fetch-owned entry, including the tail this cycle
//   tag_i      owner of the command issued this cycle
//   tailTag_o  owner of the read data arriving from the RAM this cycle
module resp_tag_pipe
   import cpu_mem_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic flush_i,
   input  tag_e tag_i,
   output tag_e tailTag_o
);

   tag_e stage_q [DEPTH];

   // Shift tags one stage per cycle. While flush is high, fetch tags are
   // dropped on the way in and on the way through the pipe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= TAG_NONE;
         end
      end else begin
         stage_q[0] <= squashTag(tag_i, flush_i);
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= squashTag(stage_q[i-1], flush_i);
         end
      end
   end

   // The tail is also masked combinationally, so a flush suppresses the
   // fetch response that is landing in the same cycle.
   assign tailTag_o = squashTag(stage_q[DEPTH-1], flush_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported RAM arbiter for instruction fetch, data read and data write.
// It issues at most one RAM command per cycle. Data requests win over fetch,
// except when fetch has been starved for STARVE_MAX cycles in a row. Read
// data goes back to its owner RD_LATENCY cycles after the command.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   flush_i                        pipeline flush, cancels fetch responses
//   if_req_i/if_addr_i             fetch request and address
//   if_gnt_o                       fetch accepted this cycle
//   if_rvalid_o/if_rdata_o         fetch response
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  data request (we == 0 means read)
//   d_gnt_o                        data accepted this cycle
//   d_rvalid_o/d_rdata_o           data read response
//   ram_en_o/ram_we_o/ram_addr_o/ram_wdata_o  RAM command
//   ram_rdata_i                    RAM read data, RD_LATENCY after the command
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int STARVE_MAX = 3,
   parameter int AW         = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_i,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic          if_gnt_o,
   output logic          if_rvalid_o,
   output logic [31:0]   if_rdata_o,
   input  logic          d_req_i,
   input  logic [3:0]    d_we_i,
   input  logic [AW-1:0] d_addr_i,
   input  logic [31:0]   d_wdata_i,
   output logic          d_gnt_o,
   output logic          d_rvalid_o,
   output logic [31:0]   d_rdata_o,
   output logic          ram_en_o,
   output logic [3:0]    ram_we_o,
   output logic [AW-1:0] ram_addr_o,
   output logic [31:0]   ram_wdata_o,
   input  logic [31:0]   ram_rdata_i
);

   localparam int            CW         = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   logic [CW-1:0] starveCnt_q, starveCnt_d;
   logic          ifGnt, dGnt;
   tag_e          issueTag, tailTag;

   // Grant selection. Reset also masks the grants, so the pipeline sees no
   // accepted request while rst_ni is low, even with requests held high.
   always_comb begin
      ifGnt = 1'b0;
      dGnt  = 1'b0;
      if (rst_ni) begin
         if (if_req_i && (!d_req_i || (starveCnt_q == STARVE_LIM))) begin
            ifGnt = 1'b1;
         end else if (d_req_i) begin
            dGnt = 1'b1;
         end
      end
   end

   // Count consecutive cycles in which fetch asks and loses. The count
   // saturates at STARVE_MAX. It clears once fetch is served or stops asking.
   always_comb begin
      starveCnt_d = starveCnt_q;
      if (!if_req_i || ifGnt) begin
         starveCnt_d = '0;
      end else if (starveCnt_q != STARVE_LIM) begin
         starveCnt_d = starveCnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starveCnt_q <= '0;
      end else begin
         starveCnt_q <= starveCnt_d;
      end
   end

   // The RAM command comes from whichever requester won. All fields are
   // zero when no requester is granted.
   always_comb begin
      ram_we_o    = WE_NONE;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      if (dGnt) begin
         ram_we_o    = d_we_i;
         ram_addr_o  = d_addr_i;
         ram_wdata_o = d_wdata_i;
      end else if (ifGnt) begin
         ram_addr_o  = if_addr_i;
      end
   end

   // Tag the command so its read data can be routed back. Writes and
   // fetches issued during a flush get no response.
   always_comb begin
      issueTag = TAG_NONE;
      if (ifGnt && !flush_i) begin
         issueTag = TAG_IF;
      end else if (dGnt && (d_we_i == WE_NONE)) begin
         issueTag = TAG_D;
      end
   end

   resp_tag_pipe #(
      .DEPTH(RD_LATENCY)
   ) uTagPipe (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .flush_i  (flush_i),
      .tag_i    (issueTag),
      .tailTag_o(tailTag)
   );

   assign if_gnt_o    = ifGnt;
   assign d_gnt_o     = dGnt;
   assign ram_en_o    = ifGnt | dGnt;

   // Only the owner of the returning word sees it. The other requester's
   // rdata output is held at zero.
   assign if_rvalid_o = (tailTag == TAG_IF);
   assign d_rvalid_o  = (tailTag == TAG_D);
   assign if_rdata_o  = if_rvalid_o ? ram_rdata_i : 32'd0;
   assign d_rdata_o   = d_rvalid_o  ? ram_rdata_i : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with RD_LATENCY=1 and STARVE_MAX=3.
// A behavioural RAM answers the arbiter's commands. Word w of the RAM holds
// 0xC0DE0000 ^ (4*w) at start-up. Expected read data comes from expWord().
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rstN;
   logic        flush, ifReq, dReq;
   logic [31:0] ifAddr, dAddr, dWdata;
   logic [3:0]  dWe;
   logic        ifGnt, ifRvalid, dGnt, dRvalid, ramEn;
   logic [31:0] ifRdata, dRdata, ramAddr, ramWdata, ramRdata;
   logic [3:0]  ramWe;
   logic [31:0] mem [256];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic        rstN, flush, ifReq, dReq;
      logic [31:0] ifAddr;
      logic [3:0]  dWe;
      logic [31:0] dAddr, dWdata;
      logic        expIfGnt, expDGnt, expIfRv, expDRv;
      logic [31:0] expIfRd, expDRd;
   } vec_t;

   vec_t vecs[$];

   mem_port_arbiter #(
      .RD_LATENCY(1),
      .STARVE_MAX(3),
      .AW        (32)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rstN),
      .flush_i    (flush),
      .if_req_i   (ifReq),
      .if_addr_i  (ifAddr),
      .if_gnt_o   (ifGnt),
      .if_rvalid_o(ifRvalid),
      .if_rdata_o (ifRdata),
      .d_req_i    (dReq),
      .d_we_i     (dWe),
      .d_addr_i   (dAddr),
      .d_wdata_i  (dWdata),
      .d_gnt_o    (dGnt),
      .d_rvalid_o (dRvalid),
      .d_rdata_o  (dRdata),
      .ram_en_o   (ramEn),
      .ram_we_o   (ramWe),
      .ram_addr_o (ramAddr),
      .ram_wdata_o(ramWdata),
      .ram_rdata_i(ramRdata)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM with one cycle of read latency and byte writes
   always @(posedge clk) begin
      if (ramEn) begin
         if (ramWe != 4'b0000) begin
            for (int b = 0; b < 4; b++) begin
               if (ramWe[b]) mem[ramAddr[9:2]][8*b +: 8] <= ramWdata[8*b +: 8];
            end
         end else begin
            ramRdata <= mem[ramAddr[9:2]];
         end
      end
   end

   // Requesters must hold their address while a request waits for its grant
   logic        ifPend = 1'b0, dPend = 1'b0;
   logic [31:0] ifAddrPrev, dAddrPrev;
   always @(posedge clk) begin
      if (rstN && ifPend && ifReq && (ifAddr !== ifAddrPrev))
         $error("[TB] protocol violation: if_addr changed while waiting");
      if (rstN && dPend && dReq && (dAddr !== dAddrPrev))
         $error("[TB] protocol violation: d_addr changed while waiting");
      ifPend     = ifReq & ~ifGnt;
      dPend      = dReq & ~dGnt;
      ifAddrPrev = ifAddr;
      dAddrPrev  = dAddr;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] expWord(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   function automatic vec_t mk(string n, logic r, logic fl, logic ir, logic [31:0] ia,
                               logic dr, logic [3:0] we, logic [31:0] da, logic [31:0] wd,
                               logic eig, logic edg, logic eir, logic [31:0] eid,
                               logic edr, logic [31:0] edd);
      vec_t v;
      v.name = n; v.rstN = r; v.flush = fl; v.ifReq = ir; v.ifAddr = ia;
      v.dReq = dr; v.dWe = we; v.dAddr = da; v.dWdata = wd;
      v.expIfGnt = eig; v.expDGnt = edg; v.expIfRv = eir; v.expIfRd = eid;
      v.expDRv = edr; v.expDRd = edd;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge
   task automatic applyStimulus(input vec_t v);
      @(posedge clk);
      #1;
      rstN = v.rstN; flush = v.flush; ifReq = v.ifReq; ifAddr = v.ifAddr;
      dReq = v.dReq; dWe = v.dWe; dAddr = v.dAddr; dWdata = v.dWdata;
   endtask

   // Outputs are sampled on the falling edge. The RAM command fields
   // follow from the grants this row expects.
   task automatic checkRow(input vec_t v);
      @(negedge clk);
      checkOutput({v.name, " if_gnt"}, 32'(ifGnt), 32'(v.expIfGnt));
      checkOutput({v.name, " d_gnt"}, 32'(dGnt), 32'(v.expDGnt));
      checkOutput({v.name, " ram_en"}, 32'(ramEn), 32'(v.expIfGnt | v.expDGnt));
      checkOutput({v.name, " ram_we"}, 32'(ramWe), v.expDGnt ? 32'(v.dWe) : 32'd0);
      checkOutput({v.name, " ram_addr"}, ramAddr,
                  v.expDGnt ? v.dAddr : (v.expIfGnt ? v.ifAddr : 32'd0));
      checkOutput({v.name, " ram_wdata"}, ramWdata, v.expDGnt ? v.dWdata : 32'd0);
      checkOutput({v.name, " if_rvalid"}, 32'(ifRvalid), 32'(v.expIfRv));
      checkOutput({v.name, " if_rdata"}, ifRdata, v.expIfRd);
      checkOutput({v.name, " d_rvalid"}, 32'(dRvalid), 32'(v.expDRv));
      checkOutput({v.name, " d_rdata"}, dRdata, v.expDRd);
   endtask

   task automatic idleInputs();
      flush = 1'b0; ifReq = 1'b0; dReq = 1'b0;
      ifAddr = '0; dAddr = '0; dWdata = '0; dWe = 4'b0000;
   endtask

   initial begin
      int          dIdx;
      logic        ifDone, expIf, expDrv;
      logic [31:0] lastDAddr;

      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 ^ (32'(i) * 32'd4);
      ramRdata = '0;
      rstN = 1'b0;
      idleInputs();

      //          name       rst fl  ifR ifAddr   dR  we    dAddr    wdata          ifG dG ifRv ifRd                      dRv dRd
      vecs.push_back(mk("rst hold",  0, 0, 1, 32'h0,  0, 4'h0, 32'h0,   32'h0,         0, 0, 0, 32'h0,                    0, 32'h0));
      vecs.push_back(mk("rst rel",   1, 0, 1, 32'h0,  0, 4'h0, 32'h0,   32'h0,         1, 0, 0, 32'h0,                    0, 32'h0));
      vecs.push_back(mk("fetch4",    1, 0, 1, 32'h4,  0, 4'h0, 32'h0,   32'h0,         1, 0, 1, expWord(32'h0),           0, 32'h0));
      vecs.push_back(mk("fetch8",    1, 0, 1, 32'h8,  0, 4'h0, 32'h0,   32'h0,         1, 0, 1, expWord(32'h4),           0, 32'h0));
      vecs.push_back(mk("fetch end", 1, 0, 0, 32'h0,  0, 4'h0, 32'h0,   32'h0,         0, 0, 1, expWord(32'h8),           0, 32'h0));
      vecs.push_back(mk("collide",   1, 0, 1, 32'hC,  1, 4'h0, 32'h100, 32'h0,         0, 1, 0, 32'h0,                    0, 32'h0));
      vecs.push_back(mk("loser",     1, 0, 1, 32'hC,  0, 4'h0, 32'h0,   32'h0,         1, 0, 0, 32'h0,                    1, expWord(32'h100)));
      vecs.push_back(mk("loser rsp", 1, 0, 0, 32'h0,  0, 4'h0, 32'h0,   32'h0,         0, 0, 1, expWord(32'hC),           0, 32'h0));
      vecs.push_back(mk("write",     1, 0, 0, 32'h0,  1, 4'h3, 32'h40,  32'hDEADBEEF,  0, 1, 0, 32'h0,                    0, 32'h0));
      vecs.push_back(mk("wr norsp",  1, 0, 0, 32'h0,  0, 4'h0, 32'h0,   32'h0,         0, 0, 0, 32'h0,                    0, 32'h0));
      vecs.push_back(mk("rd 40",     1, 0, 0, 32'h0,  1, 4'h0, 32'h40,  32'h0,         0, 1, 0, 32'h0,                    0, 32'h0));
      vecs.push_back(mk("rd 40 rsp", 1, 0, 0, 32'h0,  0, 4'h0, 32'h0,   32'h0,         0, 0, 0, 32'h0,                    1, 32'hC0DEBEEF));
      vecs.push_back(mk("fl fetch",  1, 0, 1, 32'h20, 0, 4'h0, 32'h0,   32'h0,         1, 0, 0, 32'h0,                    0, 32'h0));
      vecs.push_back(mk("fl tail",   1, 1, 0, 32'h0,  1, 4'h0, 32'h80,  32'h0,         0, 1, 0, 32'h0,                    0, 32'h0));
      vecs.push_back(mk("fl drsp",   1, 0, 0, 32'h0,  0, 4'h0, 32'h0,   32'h0,         0, 0, 0, 32'h0,                    1, expWord(32'h80)));
      vecs.push_back(mk("fl grant",  1, 1, 1, 32'h24, 0, 4'h0, 32'h0,   32'h0,         1, 0, 0, 32'h0,                    0, 32'h0));
      vecs.push_back(mk("fl squash", 1, 0, 0, 32'h0,  0, 4'h0, 32'h0,   32'h0,         0, 0, 0, 32'h0,                    0, 32'h0));
      vecs.push_back(mk("pre rst",   1, 0, 1, 32'h28, 0, 4'h0, 32'h0,   32'h0,         1, 0, 0, 32'h0,                    0, 32'h0));
      vecs.push_back(mk("mid rst",   0, 0, 0, 32'h0,  0, 4'h0, 32'h0,   32'h0,         0, 0, 0, 32'h0,                    0, 32'h0));
      vecs.push_back(mk("post rst",  1, 0, 0, 32'h0,  0, 4'h0, 32'h0,   32'h0,         0, 0, 0, 32'h0,                    0, 32'h0));

      repeat (2) @(posedge clk);
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkRow(vecs[i]);
      end

      // Starvation: data reads stream every cycle while fetch waits. Fetch
      // should win on the fourth cycle and then drop its request.
      dIdx = 0; ifDone = 1'b0; lastDAddr = '0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         dReq = 1'b1; dWe = 4'b0000; dAddr = 32'h200 + 32'(dIdx) * 32'd4;
         ifReq = !ifDone; ifAddr = 32'h300;
         @(negedge clk);
         expIf  = (c == 4);
         expDrv = (c >= 2) && (c != 5);
         checkOutput("starve if_gnt", 32'(ifGnt), 32'(expIf));
         checkOutput("starve d_gnt", 32'(dGnt), 32'(!expIf));
         checkOutput("starve if_rvalid", 32'(ifRvalid), 32'(c == 5));
         checkOutput("starve if_rdata", ifRdata, (c == 5) ? expWord(32'h300) : 32'd0);
         checkOutput("starve d_rvalid", 32'(dRvalid), 32'(expDrv));
         if (expDrv) checkOutput("starve d_rdata", dRdata, expWord(lastDAddr));
         if (expIf) ifDone = 1'b1;
         else begin
            lastDAddr = dAddr;
            dIdx++;
         end
      end
      @(posedge clk);
      #1;
      idleInputs();
      @(negedge clk);
      checkOutput("starve last d_rdata", dRdata, expWord(lastDAddr));

      // Reset while a data read is in flight: its response must never appear
      @(posedge clk);
      #1;
      dReq = 1'b1; dAddr = 32'h84;
      @(negedge clk);
      checkOutput("rst data d_gnt", 32'(dGnt), 32'd1);
      @(posedge clk);
      #1;
      idleInputs();
      rstN = 1'b0;
      @(negedge clk);
      checkOutput("rst data d_rvalid", 32'(dRvalid), 32'd0);
      @(posedge clk);
      #1;
      rstN = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkOutput("post rst d_rvalid", 32'(dRvalid), 32'd0);
         checkOutput("post rst ram_en", 32'(ramEn), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
